// File: rtl/neuron_pkg.sv
// Shared types and width helpers for the leaky integrate-and-fire neuron.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_INTEGRATE = 2'd0,
        ST_ARMED     = 2'd1,
        ST_FIRE      = 2'd2,
        ST_REFRACT   = 2'd3
    } neuron_state_t;

    // Counter width for values 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Width that holds the sum of n_in unsigned words of in_w bits without overflow.
    function automatic int sum_width(input int n_in, input int in_w);
        return in_w + ((n_in <= 1) ? 0 : $clog2(n_in));
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/neuron_adder_tree.sv
// Combinational N_IN-way unsigned adder; the sum is forced to zero when the inputs are not valid.
module neuron_adder_tree
    import neuron_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int IN_W = 16
) (
    input  logic [N_IN*IN_W-1:0]              data_i,
    input  logic                              valid_i,
    output logic [sum_width(N_IN, IN_W)-1:0]  sum_o
);

    localparam int SUM_W = sum_width(N_IN, IN_W);

    logic [SUM_W-1:0] chan [N_IN];

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
        assign chan[gi] = valid_i ? SUM_W'(data_i[gi*IN_W +: IN_W]) : '0;
    end

    always_comb begin
        sum_o = '0;
        for (int k = 0; k < N_IN; k++) begin
            sum_o = sum_o + chan[k];
        end
    end

endmodule

// File: rtl/neuron_lif_n.sv
// Leaky integrate-and-fire neuron: saturating potential, spike released on a fixed frame slot, refractory hold.
// Optional per-frame leak is compiled in when NEURON_LEAK_EN is defined.
module neuron_lif_n
    import neuron_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int IN_W       = 16,
    parameter int ACC_W      = 20,
    parameter int THRESH     = 36,
    parameter int PERIOD     = 16,
    parameter int DELAY      = 12,
    parameter int REFRACT    = 3,
    parameter int LEAK_SHIFT = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_IN*IN_W-1:0]            inspk,
    input  logic                            in_valid,
    output logic                            spike,
    output logic [clog2_min1(PERIOD)-1:0]   slot_cnt,
    output logic [ACC_W-1:0]                potential,
    output logic                            busy
);

    localparam int SLOT_W = clog2_min1(PERIOD);
    localparam int SUM_W  = sum_width(N_IN, IN_W);
    localparam int EXT_W  = max_int(ACC_W, SUM_W) + 1;
    localparam int REFR_W = clog2_min1(REFRACT + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(PERIOD - 1);
    localparam logic [SLOT_W-1:0] SLOT_DELAY = SLOT_W'(DELAY);
    localparam logic [ACC_W-1:0]  THRESH_V   = ACC_W'(THRESH);
    localparam logic [ACC_W-1:0]  ACC_MAX    = '1;
    localparam logic [REFR_W-1:0] REFR_LOAD  = (REFRACT > 0) ? REFR_W'(REFRACT - 1) : '0;

    neuron_state_t     state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [ACC_W-1:0]  pot_q, pot_d;
    logic [REFR_W-1:0] refr_q, refr_d;
    logic              spike_q;
    logic              busy_q;

    logic [SUM_W-1:0]  sum;
    logic [ACC_W-1:0]  pot_leak;
    logic [EXT_W-1:0]  pot_ext;
    logic [ACC_W-1:0]  pot_sat;

    neuron_adder_tree #(
        .N_IN (N_IN),
        .IN_W (IN_W)
    ) u_adder (
        .data_i  (inspk),
        .valid_i (in_valid),
        .sum_o   (sum)
    );

`ifdef NEURON_LEAK_EN
    // Leak is taken on the last slot of the frame, before this cycle's input is added.
    assign pot_leak = (slot_q == SLOT_LAST) ? (pot_q - (pot_q >> LEAK_SHIFT)) : pot_q;
`else
    logic [7:0] unused_leak_shift;
    assign unused_leak_shift = 8'(LEAK_SHIFT);
    assign pot_leak          = pot_q;
`endif

    assign pot_ext = EXT_W'(pot_leak) + EXT_W'(sum);
    assign pot_sat = (pot_ext > EXT_W'(ACC_MAX)) ? ACC_MAX : pot_ext[ACC_W-1:0];

    always_comb begin
        state_d = state_q;
        pot_d   = pot_q;
        refr_d  = refr_q;
        slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;

        unique case (state_q)
            ST_INTEGRATE: begin
                pot_d = pot_sat;
                if (pot_q > THRESH_V) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                pot_d = pot_sat;
                // Potential is cleared as the spike is issued so it reads zero during the pulse.
                if (slot_q == SLOT_DELAY) begin
                    state_d = ST_FIRE;
                    pot_d   = '0;
                end
            end
            ST_FIRE: begin
                pot_d = '0;
                if (REFRACT > 0) begin
                    state_d = ST_REFRACT;
                    refr_d  = REFR_LOAD;
                end else begin
                    state_d = ST_INTEGRATE;
                end
            end
            ST_REFRACT: begin
                pot_d = '0;
                if (refr_q == '0) begin
                    state_d = ST_INTEGRATE;
                end else begin
                    refr_d = refr_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_INTEGRATE;
                pot_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_INTEGRATE;
            slot_q  <= '0;
            pot_q   <= '0;
            refr_q  <= '0;
            spike_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            pot_q   <= pot_d;
            refr_q  <= refr_d;
            spike_q <= (state_d == ST_FIRE);
            busy_q  <= (state_d != ST_INTEGRATE);
        end
    end

    assign spike     = spike_q;
    assign slot_cnt  = slot_q;
    assign potential = pot_q;
    assign busy      = busy_q;

endmodule
